decode_imm_stage: RTL and testbench



---
 rtl/decode_imm_stage_pkg.sv | 59 +++++
 rtl/inst_type_classifier.sv | 29 ++
 rtl/decode_imm_stage.sv | 119 +++++++++++
 tb/tb_decode_imm_stage.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/decode_imm_stage_pkg.sv
// Shared types for the decode stage: opcode constants, instruction format
// enum, stage state enum, the stored decoded-entry record and the
// immediate generator used by the stage.
package decode_imm_stage_pkg;

    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;

    // TYPE_R must stay at encoding 0: it is the reset value of the output.
    typedef enum logic [2:0] {
        TYPE_R = 3'd0,
        TYPE_I = 3'd1,
        TYPE_S = 3'd2,
        TYPE_B = 3'd3,
        TYPE_U = 3'd4,
        TYPE_J = 3'd5
    } InstructionType;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } DecodeStageState;

    typedef struct packed {
        logic [31:0]    inst;
        logic [31:0]    pc;
        InstructionType inst_type;
        logic [31:0]    imm;
        logic           illegal;
    } DecodedInst;

    // Immediate generator: selects the RV32 immediate layout by format.
    // R (including unrecognised opcodes) yields zero.
    function automatic logic [31:0] gen_imm(input logic [31:0] inst,
                                            input InstructionType t);
        logic [31:0] imm;
        case (t)
            TYPE_I:  imm = {{20{inst[31]}}, inst[31:20]};
            TYPE_S:  imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            TYPE_B:  imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                            inst[11:8], 1'b0};
            TYPE_U:  imm = {inst[31:12], 12'b0};
            TYPE_J:  imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                            inst[30:21], 1'b0};
            default: imm = 32'd0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/inst_type_classifier.sv
// Combinational opcode classifier: maps inst[6:0] to an instruction format
// and flags opcodes outside the supported set as illegal (reported as R).
module inst_type_classifier
    import decode_imm_stage_pkg::*;
(
    input  logic [6:0]     opcode,
    output InstructionType inst_type,
    output logic           illegal
);

    // Opcode lookup; unknown opcodes fall through to R with illegal set.
    always_comb begin
        inst_type = TYPE_R;
        illegal   = 1'b0;
        case (opcode)
            OPC_OP:                                      inst_type = TYPE_R;
            OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:  inst_type = TYPE_I;
            OPC_STORE:                                   inst_type = TYPE_S;
            OPC_BRANCH:                                  inst_type = TYPE_B;
            OPC_LUI, OPC_AUIPC:                          inst_type = TYPE_U;
            OPC_JAL:                                     inst_type = TYPE_J;
            default: begin
                inst_type = TYPE_R;
                illegal   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/decode_imm_stage.sv
// Registered decode stage. Incoming words are decoded on the way in and
// stored in a two-entry skid buffer (OUT + SKID) so that in_ready can be a
// register and never depends combinationally on out_ready.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high; the sender holds valid and its payload until that edge, and
// the receiver may change ready freely.
module decode_imm_stage
    import decode_imm_stage_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_inst,
    input  logic [31:0]    in_pc,
    input  logic           flush,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [31:0]    out_inst,
    output logic [31:0]    out_pc,
    output InstructionType out_type,
    output logic [31:0]    out_imm,
    output logic           out_illegal
);

    DecodeStageState state, state_next;
    DecodedInst      out_q, skid_q, dec;
    InstructionType  dec_type;
    logic            dec_illegal;
    logic            in_ready_q;
    logic            accept, consume;
    logic            load_out, load_skid, out_from_skid;

    inst_type_classifier u_classifier (
        .opcode    (in_inst[6:0]),
        .inst_type (dec_type),
        .illegal   (dec_illegal)
    );

    // Decode the incoming word once, before it is stored.
    always_comb begin
        dec.inst      = in_inst;
        dec.pc        = in_pc;
        dec.inst_type = dec_type;
        dec.imm       = gen_imm(in_inst, dec_type);
        dec.illegal   = dec_illegal;
    end

    assign in_ready  = in_ready_q && !rst;
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Next-state and buffer steering; flush overrides every handshake.
    always_comb begin
        state_next    = state;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            state_next = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        load_out   = 1'b1;
                        state_next = ONE;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_out   = 1'b1;
                        state_next = ONE;
                    end else if (accept) begin
                        load_skid  = 1'b1;
                        state_next = FULL;
                    end else if (consume) begin
                        state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (consume) begin
                        load_out      = 1'b1;
                        out_from_skid = 1'b1;
                        state_next    = ONE;
                    end
                end
                default: state_next = EMPTY;
            endcase
        end
    end

    // State, registered ready and entry storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
        end else begin
            state      <= state_next;
            in_ready_q <= (state_next != FULL);
            if (load_out) begin
                out_q <= out_from_skid ? skid_q : dec;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign out_inst    = out_q.inst;
    assign out_pc      = out_q.pc;
    assign out_type    = out_q.inst_type;
    assign out_imm     = out_q.imm;
    assign out_illegal = out_q.illegal;

endmodule

// File: tb/tb_decode_imm_stage.sv
// Bench for decode_imm_stage: table of decode vectors streamed through the
// stage, plus back-pressure, flush and reset sequences. A queue of expected
// output records tracks what the stage should be presenting.
module tb_decode_imm_stage;
    import decode_imm_stage_pkg::*;

    localparam int W = 100;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [31:0]    in_inst;
    logic [31:0]    in_pc;
    logic           flush;
    logic           out_valid;
    logic           out_ready;
    logic [31:0]    out_inst;
    logic [31:0]    out_pc;
    InstructionType out_type;
    logic [31:0]    out_imm;
    logic           out_illegal;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  t;
        logic [31:0] imm;
        logic        ill;
    } vec_t;

    vec_t tbl[14];

    decode_imm_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_type    (out_type),
        .out_imm     (out_imm),
        .out_illegal (out_illegal)
    );

    // Clock
    always #5 clk = ~clk;

    function automatic logic [W-1:0] exp_of(input int k);
        return {tbl[k].inst, tbl[k].pc, tbl[k].t, tbl[k].imm, tbl[k].ill};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One clock of stimulus: drive inputs, check against the model, update
    // the model for the coming edge, then wait for the next falling edge.
    task automatic cycle(input logic v, input int k, input logic rdy,
                         input logic fl, input logic r, output logic acc);
        logic [W-1:0] act;
        in_valid  = v;
        in_inst   = tbl[k].inst;
        in_pc     = tbl[k].pc;
        out_ready = rdy;
        flush     = fl;
        rst       = r;
        #1;
        check("in_ready", W'(in_ready), W'(!r && exp_q.size() < 2));
        check("out_valid", W'(out_valid), W'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            act = {out_inst, out_pc, out_type, out_imm, out_illegal};
            check("out_entry", act, exp_q[0]);
        end
        acc = 1'b0;
        if (r || fl) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready && exp_q.size() != 0)
                void'(exp_q.pop_front());
            if (in_valid && in_ready) begin
                exp_q.push_back(exp_of(k));
                acc = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, W'(out_valid), W'(0));
        check({tag, "_in_ready"}, W'(in_ready), W'(1));
        check({tag, "_out_inst"}, W'(out_inst), W'(0));
        check({tag, "_out_pc"}, W'(out_pc), W'(0));
        check({tag, "_out_type"}, W'(out_type), W'(TYPE_R));
        check({tag, "_out_imm"}, W'(out_imm), W'(0));
        check({tag, "_out_illegal"}, W'(out_illegal), W'(0));
    endtask

    initial begin
        logic acc;
        int   k;

        tbl[0]  = '{32'hFFF00093, 32'h0000_0100, TYPE_I, 32'hFFFF_FFFF, 1'b0};
        tbl[1]  = '{32'h00112623, 32'h0000_0104, TYPE_S, 32'h0000_000C, 1'b0};
        tbl[2]  = '{32'h12345037, 32'h0000_0108, TYPE_U, 32'h1234_5000, 1'b0};
        tbl[3]  = '{32'h0080006F, 32'h0000_010C, TYPE_J, 32'h0000_0008, 1'b0};
        tbl[4]  = '{32'h0000007F, 32'h0000_0110, TYPE_R, 32'h0000_0000, 1'b1};
        tbl[5]  = '{32'h002081B3, 32'h0000_0114, TYPE_R, 32'h0000_0000, 1'b0};
        tbl[6]  = '{32'hFE000EE3, 32'h0000_0118, TYPE_B, 32'hFFFF_FFFC, 1'b0};
        tbl[7]  = '{32'hFFFFF017, 32'h0000_011C, TYPE_U, 32'hFFFF_F000, 1'b0};
        tbl[8]  = '{32'hFF812083, 32'h0000_0120, TYPE_I, 32'hFFFF_FFF8, 1'b0};
        tbl[9]  = '{32'h000080E7, 32'h0000_0124, TYPE_I, 32'h0000_0000, 1'b0};
        tbl[10] = '{32'h00000073, 32'h0000_0128, TYPE_I, 32'h0000_0000, 1'b0};
        tbl[11] = '{32'hFE112E23, 32'h0000_012C, TYPE_S, 32'hFFFF_FFFC, 1'b0};
        tbl[12] = '{32'hFF9FF06F, 32'h0000_0130, TYPE_J, 32'hFFFF_FFF8, 1'b0};
        tbl[13] = '{32'hFFFFFFFF, 32'h0000_0134, TYPE_R, 32'h0000_0000, 1'b1};

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        flush     = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);

        // Reset held for two cycles, with fetch offering an instruction.
        cycle(1'b1, 0, 1'b1, 1'b0, 1'b1, acc);
        cycle(1'b1, 0, 1'b1, 1'b0, 1'b1, acc);
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(negedge clk);

        // Stream the whole table back-to-back with execute always ready.
        for (int i = 0; i < 14; i++) begin
            cycle(1'b1, i, 1'b1, 1'b0, 1'b0, acc);
            if (!acc) check("stream_accept", W'(acc), W'(1));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);

        // Back-pressure: three instructions offered, execute stalled 3 cycles.
        k = 0;
        for (int c = 0; c < 12 && (k < 3 || exp_q.size() != 0); c++) begin
            if (c == 2) check("bp_in_ready_low", W'(in_ready), W'(0));
            cycle(k < 3, (k < 3) ? k : 0, c >= 3, 1'b0, 1'b0, acc);
            if (acc) k++;
        end
        if (k < 3 || exp_q.size() != 0)
            check("bp_timeout", W'(exp_q.size()), W'(0));

        // Flush while FULL, with a new instruction offered the same cycle.
        cycle(1'b1, 8, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 9, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b1, 10, 1'b0, 1'b1, 1'b0, acc);
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        check("flush_out_valid", W'(out_valid), W'(0));
        check("flush_in_ready", W'(in_ready), W'(1));
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);

        // Reset pulse while ONE and stalled, then normal operation resumes.
        cycle(1'b1, 11, 1'b0, 1'b0, 1'b0, acc);
        cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        rst = 1'b0;
        #1;
        check_reset_outputs("rst_pulse");
        @(negedge clk);
        cycle(1'b1, 12, 1'b1, 1'b0, 1'b0, acc);
        cycle(1'b1, 6, 1'b1, 1'b0, 1'b0, acc);
        for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        check("final_drain", W'(exp_q.size()), W'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
